fifo_write_arbiter: RTL and testbench

- Round-robin arbiter that shares the async FIFO's single write port between NUM_REQ producers in the write clock domain.
- Drives the FIFO's write increment and write data.
- Consumes the registered full flag from the write-pointer block.
- Grants in bounded bursts so that one producer cannot starve the others.

---
 rtl/fifo_arb_pkg.sv | 12 +
 rtl/rr_pick.sv | 29 ++
 rtl/fifo_write_arbiter.sv | 125 ++++++++++++
 tb/tb_fifo_write_arbiter.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic [0:0] {ARB_IDLE, ARB_BURST} arb_state_t;

  localparam int unsigned STAT_WIDTH = 16;

  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set request above last_grant, with wrap.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic               found,
  output logic [IDX_W-1:0]   idx
);

  int unsigned cand;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = 0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = (32'(last_grant) + k) % NUM_REQ;
      if (!found && req[IDX_W'(cand)]) begin
        found = 1'b1;
        idx   = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin, burst-bounded arbiter sharing one async-FIFO write port.
// Define FIFO_ARB_STATS_EN to add per-producer saturating word counters (stat_words).
module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MAX_BURST  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          full,
  output logic                          winc,
  output logic [DATA_WIDTH-1:0]         wdata,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          busy
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [NUM_REQ*STAT_WIDTH-1:0] stat_words
`endif
);

  localparam int unsigned IDX_W = id_width(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

  arb_state_t        state_q, state_d;
  logic [IDX_W-1:0]  grant_q, grant_d;
  logic [IDX_W-1:0]  last_q, last_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  cnt_inc;
  logic              pick_found;
  logic [IDX_W-1:0]  pick_idx;
  logic              cur_valid;
  logic              xfer;

  logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_data
    assign data_arr[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req        (req_valid),
    .last_grant (last_q),
    .found      (pick_found),
    .idx        (pick_idx)
  );

  assign cur_valid = req_valid[grant_q];
  assign cnt_inc   = cnt_q + CNT_W'(1);

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    req_ready = '0;
    xfer      = 1'b0;
    unique case (state_q)
      ARB_IDLE: begin
        if (pick_found && !full) begin
          grant_d = pick_idx;
          cnt_d   = '0;
          state_d = ARB_BURST;
        end
      end
      ARB_BURST: begin
        req_ready[grant_q] = !full && !rst;
        xfer               = cur_valid && !full && !rst;
        if (!cur_valid) begin
          state_d = ARB_IDLE;
          last_d  = grant_q;
        end else if (xfer) begin
          cnt_d = cnt_inc;
          if (req_last[grant_q] || cnt_inc == CNT_W'(MAX_BURST)) begin
            state_d = ARB_IDLE;
            last_d  = grant_q;
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      last_q  <= IDX_W'(NUM_REQ - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy     = (state_q == ARB_BURST);
  assign winc     = xfer;
  assign wdata    = busy ? data_arr[grant_q] : '0;
  assign grant_id = grant_q;

`ifdef FIFO_ARB_STATS_EN
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_stat
    logic [STAT_WIDTH-1:0] words_q;
    always_ff @(posedge clk) begin
      if (rst) begin
        words_q <= '0;
      end else if (winc && grant_q == IDX_W'(i) && words_q != '1) begin
        words_q <= words_q + 1'b1;
      end
    end
    assign stat_words[i*STAT_WIDTH +: STAT_WIDTH] = words_q;
  end
`endif

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Self-checking bench for fifo_write_arbiter: directed scenarios plus random traffic vs a model.
module tb_fifo_write_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MB = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req_valid, req_last, req_ready;
  logic [N*DW-1:0] req_data;
  logic          full, winc, busy;
  logic [DW-1:0] wdata;
  logic [1:0]    grant_id;
`ifdef FIFO_ARB_STATS_EN
  logic [N*16-1:0] stat_words;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fifo_write_arbiter #(
    .NUM_REQ    (N),
    .DATA_WIDTH (DW),
    .MAX_BURST  (MB)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_last   (req_last),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .full       (full),
    .winc       (winc),
    .wdata      (wdata),
    .grant_id   (grant_id),
    .busy       (busy)
`ifdef FIFO_ARB_STATS_EN
    ,
    .stat_words (stat_words)
`endif
  );

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = '0; req_last = '0; req_data = '0; full = 1'b0;
    next_cycle();
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (winc !== 1'b0) begin bad++; $display("FAIL reset_winc: got %b want 0", winc); end
    total++; if (req_ready !== 4'b0) begin bad++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
    total++; if (grant_id !== 2'd0) begin bad++; $display("FAIL reset_grant: got %0d want 0", grant_id); end
  endtask

  task automatic test_single_producer();
    logic [DW-1:0] words [3];
    words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33;
    do_reset();
    req_valid = 4'b0100;
    req_data[2*DW +: DW] = words[0];
    @(negedge clk);
    total++; if (winc !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL single_bubble: got winc=%b busy=%b want 0 0", winc, busy);
    end
    for (int w = 0; w < 3; w++) begin
      next_cycle();
      req_data[2*DW +: DW] = words[w];
      req_last[2] = (w == 2);
      @(negedge clk);
      total++; if (winc !== 1'b1 || wdata !== words[w] || grant_id !== 2'd2 || busy !== 1'b1) begin
        bad++; $display("FAIL single_word%0d: got winc=%b wdata=%h grant=%0d busy=%b want 1 %h 2 1",
                        w, winc, wdata, grant_id, busy, words[w]);
      end
    end
    next_cycle();
    req_valid = '0; req_last = '0;
    @(negedge clk);
    total++; if (busy !== 1'b0 || winc !== 1'b0) begin
      bad++; $display("FAIL single_release: got busy=%b winc=%b want 0 0", busy, winc);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < N; i++) req_data[i*DW +: DW] = 8'hA0 + 8'(i);
    req_valid = 4'b1111;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      total++; if (winc !== (c % 5 != 0)) begin
        bad++; $display("FAIL rr_winc c%0d: got %b want %b", c, winc, (c % 5 != 0));
      end
      if (c % 5 != 0) begin
        total++; if (grant_id !== 2'((c / 5) % 4) || wdata !== 8'hA0 + 8'((c / 5) % 4)) begin
          bad++; $display("FAIL rr_grant c%0d: got grant=%0d wdata=%h want %0d %h",
                          c, grant_id, wdata, (c / 5) % 4, 8'hA0 + 8'((c / 5) % 4));
        end
      end
      next_cycle();
    end
    req_valid = '0;
  endtask

  task automatic test_full_stall();
    int sent = 0;
    int seen = 0;
    logic exp_w;
    do_reset();
    req_valid = 4'b0010;
    for (int c = 0; c <= 10; c++) begin
      full = (c >= 3 && c <= 7);
      req_data[1*DW +: DW] = 8'h50 + 8'(sent);
      exp_w = (c == 1 || c == 2 || c == 8 || c == 9);
      @(negedge clk);
      if (winc === 1'b1) seen++;
      total++; if (winc !== exp_w) begin
        bad++; $display("FAIL stall_winc c%0d: got %b want %b", c, winc, exp_w);
      end
      if (full) begin
        total++; if (req_ready !== 4'b0 || grant_id !== 2'd1 || busy !== 1'b1) begin
          bad++; $display("FAIL stall_hold c%0d: got ready=%b grant=%0d busy=%b want 0000 1 1",
                          c, req_ready, grant_id, busy);
        end
      end
      if (exp_w) begin
        total++; if (wdata !== 8'h50 + 8'(sent)) begin
          bad++; $display("FAIL stall_data c%0d: got %h want %h", c, wdata, 8'h50 + 8'(sent));
        end
        sent++;
      end
      if (c == 10) begin
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL stall_release: got %b want 0", busy); end
      end
      next_cycle();
    end
    total++; if (seen != 4) begin bad++; $display("FAIL stall_count: got %0d want 4", seen); end
    req_valid = '0; full = 1'b0;
  endtask

  task automatic test_withdraw();
    do_reset();
    req_valid = 4'b0001;
    @(negedge clk);
    next_cycle();
    @(negedge clk);
    total++; if (winc !== 1'b1 || grant_id !== 2'd0) begin
      bad++; $display("FAIL wd_first: got winc=%b grant=%0d want 1 0", winc, grant_id);
    end
    next_cycle();
    req_valid = 4'b0000;
    @(negedge clk);
    total++; if (winc !== 1'b0 || busy !== 1'b1) begin
      bad++; $display("FAIL wd_drop: got winc=%b busy=%b want 0 1", winc, busy);
    end
    next_cycle();
    req_valid = 4'b1001;
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL wd_idle: got %b want 0", busy); end
    next_cycle();
    @(negedge clk);
    total++; if (busy !== 1'b1 || grant_id !== 2'd3 || winc !== 1'b1) begin
      bad++; $display("FAIL wd_next: got busy=%b grant=%0d winc=%b want 1 3 1", busy, grant_id, winc);
    end
    next_cycle();
    req_valid = '0;
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    req_valid = 4'b0010;
    @(negedge clk);
    next_cycle();
    @(negedge clk);
    total++; if (winc !== 1'b1 || grant_id !== 2'd1) begin
      bad++; $display("FAIL rstmid_word: got winc=%b grant=%0d want 1 1", winc, grant_id);
    end
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    total++; if (winc !== 1'b0) begin bad++; $display("FAIL rstmid_winc: got %b want 0", winc); end
    next_cycle();
    rst = 1'b0;
    req_valid = 4'b0011;
    @(negedge clk);
    total++; if (busy !== 1'b0 || winc !== 1'b0 || grant_id !== 2'd0) begin
      bad++; $display("FAIL rstmid_after: got busy=%b winc=%b grant=%0d want 0 0 0", busy, winc, grant_id);
    end
    next_cycle();
    @(negedge clk);
    total++; if (busy !== 1'b1 || grant_id !== 2'd0) begin
      bad++; $display("FAIL rstmid_regrant: got busy=%b grant=%0d want 1 0", busy, grant_id);
    end
    next_cycle();
    req_valid = '0;
  endtask

  // Reference model: owner is the producer holding the port, -1 while arbitrating.
  task automatic test_random();
    int owner = -1;
    int prev  = N - 1;
    int shown = 0;
    int taken = 0;
    int cnt [N];
    logic [N-1:0]  e_ready;
    logic          e_winc;
    logic [DW-1:0] e_data;
    for (int i = 0; i < N; i++) cnt[i] = 0;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        req_valid[i] = ($urandom_range(7) != 0);
        req_last[i]  = ($urandom_range(3) == 0);
        req_data[i*DW +: DW] = 8'($urandom);
      end
      full = ($urandom_range(4) == 0);
      @(negedge clk);
      e_ready = (owner >= 0 && !full) ? (4'b0001 << owner) : 4'b0000;
      e_winc  = (owner >= 0) && req_valid[owner] && !full;
      e_data  = (owner >= 0) ? req_data[owner*DW +: DW] : '0;
      total++; if (winc !== e_winc || req_ready !== e_ready || busy !== (owner >= 0)) begin
        bad++; $display("FAIL rand_ctl c%0d: got winc=%b ready=%b busy=%b want %b %b %b",
                        c, winc, req_ready, busy, e_winc, e_ready, owner >= 0);
      end
      total++; if (grant_id !== 2'(shown)) begin
        bad++; $display("FAIL rand_grant c%0d: got %0d want %0d", c, grant_id, shown);
      end
      if (owner >= 0) begin
        total++; if (wdata !== e_data) begin
          bad++; $display("FAIL rand_data c%0d: got %h want %h", c, wdata, e_data);
        end
      end
      total++; if (winc === 1'b1 && full) begin
        bad++; $display("FAIL rand_full_write c%0d: got winc=1 want 0", c);
      end
      if (owner < 0) begin
        if (req_valid != '0 && !full) begin
          for (int k = 1; k <= N; k++) begin
            if (req_valid[(prev + k) % N]) begin owner = (prev + k) % N; break; end
          end
          shown = owner;
          taken = 0;
        end
      end else if (!req_valid[owner]) begin
        prev = owner; owner = -1;
      end else if (e_winc) begin
        taken++;
        cnt[owner]++;
        if (req_last[owner] || taken == MB) begin prev = owner; owner = -1; end
      end
      next_cycle();
    end
    req_valid = '0; full = 1'b0;
`ifdef FIFO_ARB_STATS_EN
    for (int i = 0; i < N; i++) begin
      total++; if (stat_words[i*16 +: 16] !== 16'(cnt[i])) begin
        bad++; $display("FAIL stat%0d: got %0d want %0d", i, stat_words[i*16 +: 16], cnt[i]);
      end
    end
`endif
  endtask

  initial begin
    test_reset();
    test_single_producer();
    test_round_robin();
    test_full_stall();
    test_withdraw();
    test_reset_mid_burst();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
